// File: rtl/complex_mult_pkg.sv
// Definitions shared by the complex multiplier, its result accumulator and their benches:
// the accumulator state encoding and the lane-width helpers.
package complex_mult_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_LEN    = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } acc_state_t;

    // A product of two unsigned complex operands needs two extra bits:
    // one for the cross-term sum and one for the sign.
    function automatic int res_width(input int data_width);
        return 2 * data_width + 2;
    endfunction

    function automatic int acc_width(input int res_w, input int acc_len);
        return res_w + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/complex_result_accumulator.sv
// Sums groups of ACC_LEN complex products, one lane each for real and imaginary parts.
// Each sum is presented on a registered valid/ready output, and flush can end a group early.
module complex_result_accumulator
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RES_WIDTH  = res_width(DATA_WIDTH),
    parameter int ACC_LEN    = DEF_ACC_LEN,
    parameter int ACC_WIDTH  = acc_width(RES_WIDTH, ACC_LEN),
    parameter int CNT_WIDTH  = $clog2(ACC_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sw_rst,
    input  logic                 res_val,
    output logic                 res_ready,
    input  logic [RES_WIDTH-1:0] res_re,
    input  logic [RES_WIDTH-1:0] res_im,
    input  logic                 flush,
    output logic                 acc_val,
    input  logic                 acc_ready,
    output logic [ACC_WIDTH-1:0] acc_re,
    output logic [ACC_WIDTH-1:0] acc_im,
    output logic [CNT_WIDTH-1:0] acc_cnt
);

    localparam logic [CNT_WIDTH-1:0] LEN_C = CNT_WIDTH'(ACC_LEN);

    acc_state_t                   r_state;
    logic                         r_res_ready;
    logic                         r_acc_val;
    logic signed [ACC_WIDTH-1:0]  r_acc_re;
    logic signed [ACC_WIDTH-1:0]  r_acc_im;
    logic        [CNT_WIDTH-1:0]  r_cnt;

    logic                         w_accept;
    logic                         w_close;
    logic signed [ACC_WIDTH-1:0]  w_re_ext;
    logic signed [ACC_WIDTH-1:0]  w_im_ext;
    logic        [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_re_ext  = {{(ACC_WIDTH-RES_WIDTH){res_re[RES_WIDTH-1]}}, res_re};
    assign w_im_ext  = {{(ACC_WIDTH-RES_WIDTH){res_im[RES_WIDTH-1]}}, res_im};
    assign w_accept  = res_val & r_res_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // A group closes when it fills up, or on flush if it holds at least one product.
    assign w_close = (w_accept && (w_cnt_inc == LEN_C)) ||
                     (flush && ((r_cnt != '0) || w_accept));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ACCUM;
            r_res_ready <= 1'b1;
            r_acc_val   <= 1'b0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
        end else if (sw_rst) begin
            r_state     <= ACCUM;
            r_res_ready <= 1'b1;
            r_acc_val   <= 1'b0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc_re <= r_acc_re + w_re_ext;
                        r_acc_im <= r_acc_im + w_im_ext;
                        r_cnt    <= w_cnt_inc;
                    end
                    if (w_close) begin
                        r_state     <= OUT;
                        r_res_ready <= 1'b0;
                        r_acc_val   <= 1'b1;
                    end
                end
                OUT: begin
                    if (acc_ready) begin
                        r_state     <= ACCUM;
                        r_res_ready <= 1'b1;
                        r_acc_val   <= 1'b0;
                        r_acc_re    <= '0;
                        r_acc_im    <= '0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_res_ready <= 1'b1;
                    r_acc_val   <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready = r_res_ready;
    assign acc_val   = r_acc_val;
    assign acc_re    = r_acc_re;
    assign acc_im    = r_acc_im;
    assign acc_cnt   = r_cnt;

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Directed bench for complex_result_accumulator with the default 8-bit operand configuration.
// Every expected value is computed by hand from the products that are fed in.
module tb_complex_result_accumulator;
    import complex_mult_pkg::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int RW  = res_width(DW);
    localparam int AL  = DEF_ACC_LEN;
    localparam int AW  = acc_width(RW, AL);
    localparam int CW  = $clog2(AL + 1);

    logic          clk;
    logic          rstn;
    logic          sw_rst;
    logic          res_val;
    logic          res_ready;
    logic [RW-1:0] res_re;
    logic [RW-1:0] res_im;
    logic          flush;
    logic          acc_val;
    logic          acc_ready;
    logic [AW-1:0] acc_re;
    logic [AW-1:0] acc_im;
    logic [CW-1:0] acc_cnt;

    int checks;
    int failures;

    complex_result_accumulator #(
        .DATA_WIDTH(DW),
        .RES_WIDTH (RW),
        .ACC_LEN   (AL),
        .ACC_WIDTH (AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sw_rst   (sw_rst),
        .res_val  (res_val),
        .res_ready(res_ready),
        .res_re   (res_re),
        .res_im   (res_im),
        .flush    (flush),
        .acc_val  (acc_val),
        .acc_ready(acc_ready),
        .acc_re   (acc_re),
        .acc_im   (acc_im),
        .acc_cnt  (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Drive the product inputs, then step one clock and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic val, input int re, input int im,
                                 input logic fl, input logic rdy);
        res_val   = val;
        res_re    = RW'(re);
        res_im    = RW'(im);
        flush     = fl;
        acc_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Sign-extend the accumulator lanes so negative sums compare as ints.
    function automatic int sre();
        return int'($signed(acc_re));
    endfunction

    function automatic int sim();
        return int'($signed(acc_im));
    endfunction

    task automatic checkAll(input string tag, input int rdy, input int val,
                            input int re, input int im, input int cnt);
        checkOutput({tag, ".res_ready"}, int'(res_ready), rdy);
        checkOutput({tag, ".acc_val"},   int'(acc_val),   val);
        checkOutput({tag, ".acc_re"},    sre(),           re);
        checkOutput({tag, ".acc_im"},    sim(),           im);
        checkOutput({tag, ".acc_cnt"},   int'(acc_cnt),   cnt);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        sw_rst    = 1'b0;
        res_val   = 1'b0;
        res_re    = '0;
        res_im    = '0;
        flush     = 1'b0;
        acc_ready = 1'b0;

        #12;
        checkAll("reset", 1, 0, 0, 0, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // (2+3i)(4+5i) = -7+22i, four times back to back
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, -7, 22, 1'b0, 1'b1);
        checkAll("basic.partial", 1, 0, -21, 66, 3);
        applyStimulus(1'b1, -7, 22, 1'b0, 1'b1);
        checkAll("basic.full", 0, 1, -28, 88, 4);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkAll("basic.drain", 1, 0, 0, 0, 0);

        // (255+255i)^2 = 0+130050i; sum fits in 20 signed bits without wrap
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 130050, 1'b0, 1'b1);
        checkAll("corner.full", 0, 1, 0, 520200, 4);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkAll("corner.drain", 1, 0, 0, 0, 0);

        // Backpressure: sum held while acc_ready is low; extra products refused
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 100, -50, 1'b0, 1'b0);
        checkAll("bp.full", 0, 1, 400, -200, 4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 999, 999, 1'b0, 1'b0);
            checkAll("bp.hold", 0, 1, 400, -200, 4);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkAll("bp.release", 1, 0, 0, 0, 0);

        // Flush of a partial group, then flush on an empty accumulator
        applyStimulus(1'b1, 10, -5, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 4, 1'b0, 1'b0);
        checkAll("flush.partial", 1, 0, 13, -1, 2);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkAll("flush.out", 0, 1, 13, -1, 2);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkAll("flush.in_out", 0, 1, 13, -1, 2);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkAll("flush.drain", 1, 0, 0, 0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        checkAll("flush.empty", 1, 0, 0, 0, 0);

        // Flush in the same cycle as an accept includes that product
        applyStimulus(1'b1, 1, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 2, 1'b1, 1'b0);
        checkAll("flushacc.out", 0, 1, 3, 3, 2);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkAll("flushacc.drain", 1, 0, 0, 0, 0);

        // Synchronous software reset mid-group, asserted together with res_val
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5, 6, 1'b0, 1'b0);
        checkAll("swrst.partial", 1, 0, 15, 18, 3);
        sw_rst = 1'b1;
        applyStimulus(1'b1, 5, 6, 1'b0, 1'b0);
        sw_rst = 1'b0;
        checkAll("swrst.cleared", 1, 0, 0, 0, 0);

        // Asynchronous reset between clock edges clears the outputs at once
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, -4, 9, 1'b0, 1'b0);
        checkAll("arst.partial", 1, 0, -12, 27, 3);
        res_val = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkAll("arst.cleared", 1, 0, 0, 0, 0);
        #1;
        rstn = 1'b1;
        applyStimulus(1'b1, 7, -3, 1'b0, 1'b0);
        checkAll("arst.resume", 1, 0, 7, -3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_result_accumulator.md
Name: complex_result_accumulator

Overview:
Downstream consumer of the complex number multiplier. Accepts products over the res_val/res_ready handshake and sums ACC_LEN consecutive products (a complex dot product). It then presents the sum on a second valid/ready interface. Real and imaginary lanes are accumulated in parallel.

Parameters:
DATA_WIDTH, 8, multiplier operand width (unsigned operands)
RES_WIDTH, 2*DATA_WIDTH+2, width of each signed product lane from the multiplier
ACC_LEN, 4, number of products summed per output group (>=2)
ACC_WIDTH, RES_WIDTH+$clog2(ACC_LEN), signed accumulator lane width; must be >= RES_WIDTH+$clog2(ACC_LEN)
CNT_WIDTH, $clog2(ACC_LEN+1), width of sample counter

Ports:
clk  input  1  clock signal
rstn  input  1  asynchronous reset active 0
sw_rst  input  1  software reset active 1, synchronous
res_val  input  1  multiplier result valid
res_ready  output  1  accumulator can accept a product
res_re  input  RES_WIDTH  signed real part of product
res_im  input  RES_WIDTH  signed imaginary part of product
flush  input  1  emit partial sum early (pulse)
acc_val  output  1  sum valid
acc_ready  input  1  sink accepts sum
acc_re  output  ACC_WIDTH  signed real sum
acc_im  output  ACC_WIDTH  signed imaginary sum
acc_cnt  output  CNT_WIDTH  number of products contained in presented sum

Behaviour:
- Reset (rstn=0 async, or sw_rst=1 at a clock edge): state=ACCUM, res_ready=1, acc_val=0, acc_re=0, acc_im=0, acc_cnt=0. sw_rst has priority over all other inputs; reset mid-group discards the partial sum.
- All outputs are registered. Inputs are sign-extended from RES_WIDTH to ACC_WIDTH before adding. No saturation: the width constraint guarantees no overflow.
- FSM has two states:
  - ACCUM: res_ready=1, acc_val=0.
  - OUT: res_ready=0, acc_val=1.
- ACCUM, accept (res_val & res_ready): acc += product and acc_cnt += 1 on that edge.
  - If this accept makes acc_cnt == ACC_LEN, go to OUT on the same edge.
  - acc_val rises the cycle after the ACC_LEN-th accept (latency 1).
- ACCUM, flush=1 with (acc_cnt>0 or accept this cycle): go to OUT. A product accepted in the same cycle is included in the sum.
- ACCUM, flush=1 with acc_cnt==0 and no accept: ignored.
- OUT: acc_re, acc_im and acc_cnt are held stable while acc_val=1 and acc_ready=0. res_val is ignored (no accept).
- OUT, acc_val & acc_ready: clear acc and acc_cnt, return to ACCUM; res_ready=1 the next cycle.
  - Min group period is ACC_LEN+1 cycles (one bubble per group).
- flush in OUT: ignored.
- res_re/res_im are sampled only on accept. Values while res_val=0 have no effect.
- acc_ready asserted while acc_val=0: no effect.

Decomposition:
- Shared package (complex_mult_pkg) holds:
  - State encoding constants ACCUM=1'b0, OUT=1'b1.
  - Width helpers: RES_WIDTH derived from DATA_WIDTH, ACC_WIDTH derived from RES_WIDTH and ACC_LEN.
  - These are reused by the multiplier and its testbench.
- No sub-module: the two lane adders are one-line expressions, and the FSM and counter are local.

Test Plan:
- Four accepts of (-7, 22), i.e. (2+3i)(4+5i), back-to-back, acc_ready=1 -> res_ready drops after 4th accept; next cycle acc_val=1, acc_re=-28, acc_im=88, acc_cnt=4; one cycle later res_ready=1, acc=0.
- Corner: four accepts of (0, 130050), i.e. (255+255i)^2 -> acc_im=520200, acc_re=0, no sign wrap (ACC_WIDTH=20).
- Backpressure: complete group with acc_ready=0 for 10 cycles -> acc_val held 1, outputs unchanged, res_ready=0, extra res_val pulses not consumed. Then acc_ready=1 for 1 cycle -> acc_val=0 next cycle.
- Flush: two accepts (10,-5), (3,4), then flush -> acc_val=1, acc_re=13, acc_im=-1, acc_cnt=2. Flush with empty accumulator -> no acc_val.
- Flush coincident with accept: accept (1,1), then accept (2,2) with flush=1 -> sum (3,3), acc_cnt=2.
- Reset mid-group: three accepts, then sw_rst=1 for one cycle -> acc_cnt=0, acc=0, state ACCUM. Same check with rstn pulsed low between clock edges -> outputs clear immediately.
